uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated TX FIFO, a runtime-selectable frame format and an internal baud divider. Frame format is 5–9 data bits, LSB first, optional even/odd parity, and 1 or 2 stop bits. Frames queued in the FIFO are sent back-to-back with no idle gap. The block sits between the bus-side register block (FIFO write port, config) and the pad (tx_out).

Parameters:
DATA_W, 9, maximum data width; wr_data width; frames use the low cfg_bits bits
FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2
DIV_W, 16, baud divider width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cfg_div  in  DIV_W  clocks per bit; values 0 and 1 are both treated as 1
cfg_bits  in  4  data bits per frame, 5..9; values <5 treated as 5, >9 treated as 9
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
cfg_stop  in  1  0 = one stop bit, 1 = two stop bits
tx_en  in  1  permit new frames to start
wr_valid  in  1  FIFO write request
wr_data  in  DATA_W  word to queue
wr_ready  out  1  FIFO not full
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse on the last clock of the final stop bit
tx_out  out  1  serial line, idle high

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, FIFO emptied, fifo_count=0, wr_ready=1, busy=0, frame_done=0, tx_out=1. Reset applies mid-frame; the line returns high the cycle after the reset edge, and the partial frame is abandoned.
- FIFO:
  - Write is accepted when wr_valid && wr_ready. wr_ready = (fifo_count != FIFO_DEPTH); it is a registered function of count only, with no combinational path from a pop.
  - Writes while full are dropped. Pop and push in the same cycle leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Config sampling: cfg_bits, cfg_parity, cfg_stop and cfg_div are latched on START entry. Changes mid-frame take effect from the next frame.
- Bit timer: counts 0..div-1 and restarts on every state/bit change. A bit lasts exactly max(cfg_div,1) clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1. If tx_en && fifo_count!=0, go to START next edge; the head entry is popped on that edge into the shift register.
  - START: tx_out=0 for one bit, then DATA with bit index 0.
  - DATA: tx_out=shift[idx]. After each bit, idx++. After bit cfg_bits-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: tx_out = XOR of the sent data bits (even), or its inverse (odd), for one bit, then STOP.
  - STOP: tx_out=1 for 1 or 2 bits. At the end of the final stop bit, frame_done=1 for that clock. If tx_en && fifo_count!=0, go directly to START with a pop (zero idle clocks); else go to IDLE.
- Frame length in clocks = div × (1 + cfg_bits + P + S), where P = 1 if parity is enabled and S = 1 + cfg_stop.
- Start latency: a write accepted at edge E0 into an empty FIFO in IDLE with tx_en=1 gives tx_out=0 from edge E1.
- tx_en deasserted mid-frame: the current frame completes normally, then the block enters IDLE. Queued data is retained.
- Data bits above cfg_bits-1 are ignored (not transmitted and not included in parity).

Test Plan:
- div=4, 8N1, write 0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks (40 clocks total); frame_done pulses once at clock 40; busy falls the next clock.
- div=2, 7 bits even parity, write 0x55 (four ones) -> parity bit 0, frame 20 clocks. Same setup with odd parity -> parity bit 1.
- div=3, 9 bits, no parity, 2 stop, write 0x1FF -> start low for 3 clocks, 27 clocks high data, 6 clocks stop; frame 36 clocks.
- FIFO_DEPTH=4, tx_en=0, write 5 words -> after 4 writes fifo_count=4, wr_ready=0, 5th word dropped. Raise tx_en with div=4, 8N1 -> four frames in 160 contiguous clocks with no idle high gap between stop and start; fifo_count steps 3,2,1,0.
- Start a frame (div=4, 8N1), drop tx_en at clock 10 with 2 words queued -> frame finishes at clock 40, then IDLE with fifo_count=2. Re-raise tx_en -> next start bit 1 clock later.
- Assert rst_n=0 at clock 15 of a frame with 3 words queued -> tx_out=1, busy=0, fifo_count=0, wr_ready=1 after that edge; no frame_done pulse.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : UART transmitter with TX FIFO, runtime frame format, baud divider.
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [3:0]                    cfg_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop,
  input  logic                          tx_en,
  input  logic                          wr_valid,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          tx_out
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_SW = 9;

  localparam logic [c_CW-1:0]  c_DEPTH   = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0]  c_CNT_ONE = c_CW'(1);
  localparam logic [c_AW-1:0]  c_PTR_ONE = c_AW'(1);
  localparam logic [DIV_W-1:0] c_DIV_ONE = DIV_W'(1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [c_CW-1:0]   w_count_nxt;
  logic              r_wr_ready;
  logic              w_push;
  logic              w_pop;
  logic [c_SW-1:0]   w_head;

  assign w_push = wr_valid && r_wr_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_CNT_ONE;
      2'b01:   w_count_nxt = r_count - c_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // wr_ready is derived from the next count so it never depends on a pop combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_count    <= w_count_nxt;
      r_wr_ready <= (w_count_nxt != c_DEPTH);
    end
  end

  generate
    if (DATA_W >= c_SW) begin : g_head_trunc
      assign w_head = r_mem[r_rd_ptr][c_SW-1:0];
    end else begin : g_head_pad
      assign w_head = {{(c_SW-DATA_W){1'b0}}, r_mem[r_rd_ptr]};
    end
  endgenerate

  // ------------------------------------------------------- config decode
  logic [DIV_W-1:0] w_div_m1;
  logic [3:0]       w_bits;
  logic             w_par_en;
  logic             w_par_odd;
  logic [c_SW-1:0]  w_mask;
  logic             w_head_par;

  assign w_div_m1 = (cfg_div > c_DIV_ONE) ? (cfg_div - c_DIV_ONE) : '0;

  always_comb begin
    w_bits = cfg_bits;
    if (cfg_bits < 4'd5) begin
      w_bits = 4'd5;
    end else if (cfg_bits > 4'd9) begin
      w_bits = 4'd9;
    end
  end

  assign w_par_en   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
  assign w_par_odd  = (cfg_parity == 2'b10);
  assign w_mask     = 9'h1FF >> (4'd9 - w_bits);
  // Parity covers only the bits actually sent; computed once at frame load
  assign w_head_par = (^(w_head & w_mask)) ^ w_par_odd;

  // ----------------------------------------------------------- frame FSM
  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [3:0]       r_idx;
  logic [3:0]       w_idx_nxt;
  logic             r_stop_cnt;
  logic             w_stop_cnt_nxt;
  logic [DIV_W-1:0] r_tick;
  logic [DIV_W-1:0] w_tick_nxt;
  logic [DIV_W-1:0] r_div_m1;
  logic [3:0]       r_bits;
  logic             r_par_en;
  logic             r_stop2;
  logic             r_par_bit;
  logic             w_par_bit_nxt;
  logic [c_SW-1:0]  r_shift;
  logic [c_SW-1:0]  w_shift_nxt;
  logic             r_tx_out;
  logic             w_tx_nxt;
  logic             w_load;
  logic             w_bit_end;
  logic             w_can_start;
  logic             w_last_stop;

  assign w_bit_end   = (r_tick == r_div_m1);
  assign w_can_start = tx_en && (r_count != '0);
  assign w_last_stop = (r_state == c_ST_STOP) && w_bit_end && (!r_stop2 || r_stop_cnt);
  assign w_pop       = w_load;

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_stop_cnt_nxt = r_stop_cnt;
    w_load         = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_can_start) begin
          w_state_nxt = c_ST_START;
          w_load      = 1'b1;
        end
      end
      c_ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = c_ST_DATA;
          w_idx_nxt   = 4'd0;
        end
      end
      c_ST_DATA: begin
        if (w_bit_end) begin
          if (r_idx == (r_bits - 4'd1)) begin
            w_state_nxt    = r_par_en ? c_ST_PARITY : c_ST_STOP;
            w_stop_cnt_nxt = 1'b0;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      c_ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = c_ST_STOP;
          w_stop_cnt_nxt = 1'b0;
        end
      end
      c_ST_STOP: begin
        if (w_last_stop) begin
          // Chain straight into the next start bit when more data is waiting
          if (w_can_start) begin
            w_state_nxt = c_ST_START;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = c_ST_IDLE;
          end
        end else if (w_bit_end) begin
          w_stop_cnt_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  assign w_tick_nxt    = ((r_state == c_ST_IDLE) || w_bit_end) ? '0 : (r_tick + c_DIV_ONE);
  assign w_shift_nxt   = w_load ? w_head : r_shift;
  assign w_par_bit_nxt = w_load ? w_head_par : r_par_bit;

  // Line level is registered from the next state so the pad never glitches
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      c_ST_START:  w_tx_nxt = 1'b0;
      c_ST_DATA:   w_tx_nxt = w_shift_nxt[w_idx_nxt];
      c_ST_PARITY: w_tx_nxt = w_par_bit_nxt;
      default:     w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_idx      <= 4'd0;
      r_stop_cnt <= 1'b0;
      r_tick     <= '0;
      r_div_m1   <= '0;
      r_bits     <= 4'd8;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_par_bit  <= 1'b0;
      r_shift    <= '0;
      r_tx_out   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_tick     <= w_tick_nxt;
      r_shift    <= w_shift_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_tx_out   <= w_tx_nxt;
      if (w_load) begin
        r_div_m1 <= w_div_m1;
        r_bits   <= w_bits;
        r_par_en <= w_par_en;
        r_stop2  <= cfg_stop;
      end
    end
  end

  assign wr_ready   = r_wr_ready;
  assign fifo_count = r_count;
  assign busy       = (r_state != c_ST_IDLE);
  assign frame_done = w_last_stop;
  assign tx_out     = r_tx_out;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Brief   : Self-checking bench for uart_tx_fifo against a frame-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DIV_W-1:0]  cfg_div;
  logic [3:0]        cfg_bits;
  logic [1:0]        cfg_parity;
  logic              cfg_stop;
  logic              tx_en;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [CW-1:0]     fifo_count;
  logic              busy;
  logic              frame_done;
  logic              tx_out;

  int total = 0;
  int bad   = 0;
  int mq[$];
  bit ebits[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_div    (cfg_div),
    .cfg_bits   (cfg_bits),
    .cfg_parity (cfg_parity),
    .cfg_stop   (cfg_stop),
    .tx_en      (tx_en),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .frame_done (frame_done),
    .tx_out     (tx_out)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int d, input int nb, input int par, input int st);
    cfg_div    = DIV_W'(d);
    cfg_bits   = 4'(nb);
    cfg_parity = 2'(par);
    cfg_stop   = 1'(st);
  endtask

  // Single write while the transmitter is not popping in the same cycle
  task automatic write_word(input int w);
    wr_valid = 1'b1;
    wr_data  = DATA_W'(w);
    cyc();
    wr_valid = 1'b0;
    if (mq.size() < FIFO_DEPTH) mq.push_back(w & 'h1FF);
  endtask

  // Walks the expected line waveform frame by frame from the model queue.
  // drop_at: clear tx_en after that clock; stop_at: return early; scramble_at: change cfg.
  task automatic check_stream(input int n_frames, input int drop_at, input int stop_at,
                              input int scramble_at);
    int clk_n;
    clk_n = 0;
    for (int f = 0; f < n_frames; f++) begin
      int d, nb, pe, po, ns, w, par, len;
      if (f > 0 && !tx_en) break;
      if (mq.size() == 0) break;
      d  = (cfg_div < 2) ? 1 : int'(cfg_div);
      nb = (cfg_bits < 5) ? 5 : ((cfg_bits > 9) ? 9 : int'(cfg_bits));
      pe = (cfg_parity == 2'b01 || cfg_parity == 2'b10) ? 1 : 0;
      po = (cfg_parity == 2'b10) ? 1 : 0;
      ns = cfg_stop ? 2 : 1;
      w  = mq.pop_front();
      ebits.delete();
      ebits.push_back(1'b0);
      par = 0;
      for (int i = 0; i < nb; i++) begin
        ebits.push_back(1'((w >> i) & 1));
        par ^= (w >> i) & 1;
      end
      if (pe != 0) ebits.push_back(1'(par ^ po));
      for (int i = 0; i < ns; i++) ebits.push_back(1'b1);
      len = d * ebits.size();
      for (int n = 0; n < len; n++) begin
        cyc();
        clk_n++;
        total++;
        if (tx_out !== ebits[n / d]) begin
          bad++;
          $display("FAIL tx_out frame %0d clk %0d: got %b want %b", f, n + 1, tx_out, ebits[n / d]);
        end
        total++;
        if (frame_done !== (n == len - 1)) begin
          bad++;
          $display("FAIL frame_done frame %0d clk %0d: got %b want %b", f, n + 1, frame_done, (n == len - 1));
        end
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy frame %0d clk %0d: got %b want 1", f, n + 1, busy);
        end
        total++;
        if (fifo_count !== CW'(mq.size())) begin
          bad++;
          $display("FAIL fifo_count frame %0d clk %0d: got %0d want %0d", f, n + 1, fifo_count, mq.size());
        end
        if (clk_n == drop_at) tx_en = 1'b0;
        if (clk_n == scramble_at)
          set_cfg($urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
        if (clk_n == stop_at) return;
      end
    end
    cyc();
    total++;
    if (busy !== 1'b0 || tx_out !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_stream: got busy=%b tx=%b done=%b want 0 1 0", busy, tx_out, frame_done);
    end
    total++;
    if (fifo_count !== CW'(mq.size())) begin
      bad++;
      $display("FAIL count_after_stream: got %0d want %0d", fifo_count, mq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_en = 1'b0; wr_valid = 1'b0; wr_data = '0;
    set_cfg(4, 8, 0, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    total++;
    if (tx_out !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx_out); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
    total++;
    if (fifo_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_single_frame(input int d, input int nb, input int par, input int st, input int w);
    set_cfg(d, nb, par, st);
    tx_en = 1'b1;
    write_word(w);
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL start_latency: got tx=%b busy=%b want 1 0", tx_out, busy);
    end
    check_stream(1, 0, 0, 0);
  endtask

  task automatic test_fifo_full();
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_word($urandom_range(0, 511));
      total++;
      if (fifo_count !== CW'((i + 1 > FIFO_DEPTH) ? FIFO_DEPTH : i + 1)) begin
        bad++;
        $display("FAIL fill_count write %0d: got %0d want %0d", i, fifo_count, (i + 1 > FIFO_DEPTH) ? FIFO_DEPTH : i + 1);
      end
      total++;
      if (wr_ready !== (i + 1 < FIFO_DEPTH)) begin
        bad++;
        $display("FAIL fill_ready write %0d: got %b want %b", i, wr_ready, (i + 1 < FIFO_DEPTH));
      end
    end
    set_cfg(4, 8, 0, 0);
    tx_en = 1'b1;
    check_stream(FIFO_DEPTH, 0, 0, 0);
  endtask

  task automatic test_tx_en_drop();
    tx_en = 1'b0;
    for (int i = 0; i < 3; i++) write_word($urandom_range(0, 511));
    set_cfg(4, 8, 0, 0);
    tx_en = 1'b1;
    check_stream(3, 10, 0, 0);
    for (int i = 0; i < 3; i++) cyc();
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_count !== CW'(2)) begin
      bad++;
      $display("FAIL hold_idle: got tx=%b busy=%b count=%0d want 1 0 2", tx_out, busy, fifo_count);
    end
    tx_en = 1'b1;
    check_stream(2, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      int k;
      tx_en = 1'b0;
      k = $urandom_range(1, FIFO_DEPTH);
      for (int i = 0; i < k; i++) write_word($urandom_range(0, 511));
      set_cfg($urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
      tx_en = 1'b1;
      check_stream(k, 0, 0, $urandom_range(2, 6));
    end
  endtask

  task automatic test_reset_mid_frame();
    tx_en = 1'b0;
    for (int i = 0; i < 3; i++) write_word($urandom_range(0, 511));
    set_cfg(4, 8, 0, 0);
    tx_en = 1'b1;
    check_stream(1, 0, 15, 0);
    rst_n = 1'b0;
    cyc();
    mq.delete();
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_line: got tx=%b busy=%b want 1 0", tx_out, busy);
    end
    total++;
    if (fifo_count !== '0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_fifo: got count=%0d ready=%b want 0 1", fifo_count, wr_ready);
    end
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_done: got %b want 0", frame_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 45; i++) begin
      cyc();
      total++;
      if (frame_done !== 1'b0 || tx_out !== 1'b1) begin
        bad++;
        $display("FAIL post_reset_quiet clk %0d: got done=%b tx=%b want 0 1", i, frame_done, tx_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame(4, 8, 0, 0, 'hA5);
    test_single_frame(2, 7, 1, 0, 'h55);
    test_single_frame(2, 7, 2, 0, 'h55);
    test_single_frame(3, 9, 0, 1, 'h1FF);
    test_single_frame(0, 3, 3, 1, 'h0F3);
    test_single_frame(1, 12, 2, 0, 'h1A6);
    test_fifo_full();
    test_tx_en_drop();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
